// File: rtl/bus_datapath_seq_if.sv
// bus_datapath_seq_if
// Groups the command handshake, direct-load port, debug read port and
// datapath observation outputs of bus_datapath_seq.
//
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both 1. The master holds cmd_op/cmd_ra/cmd_rb/cmd_rc stable
// while cmd_valid is high. The slave raises cmd_ready only when it is idle
// and no direct load (ld_en) is requested. done pulses for one cycle when the
// command completes, and err is meaningful only while done is 1.
//
// Modports:
//   master - drives commands, loads and the debug address (control unit / bench)
//   slave  - the datapath
interface bus_datapath_seq_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
);
  localparam int RA_W = $clog2(NUM_REGS);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [RA_W-1:0]   cmd_ra;
  logic [RA_W-1:0]   cmd_rb;
  logic [RA_W-1:0]   cmd_rc;
  logic              ld_en;
  logic [RA_W-1:0]   ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [RA_W-1:0]   dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [DATA_W-1:0] bus_out;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              done;
  logic              err;
  logic [2:0]        fsm_state;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc,
    output ld_en, ld_addr, ld_data, dbg_addr,
    input  cmd_ready, dbg_data, bus_out, hi_out, lo_out, done, err, fsm_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc,
    input  ld_en, ld_addr, ld_data, dbg_addr,
    output cmd_ready, dbg_data, bus_out, hi_out, lo_out, done, err, fsm_state
  );
endinterface

// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq
// Single-bus datapath (register file, Y, Z_HI/Z_LO, HI, LO, ALU) with an
// on-block T-step sequencer. A three-operand command is accepted over a
// valid/ready handshake, the sequencer walks T_Y -> T_ALU -> (T_DIV) -> T_WB
// -> (T_WBHI), and done pulses for one cycle at completion.
//
// Ports:
//   clk - rising-edge clock
//   clr - asynchronous active-low reset
//   io  - bus_datapath_seq_if.slave (command, load, debug and observation signals)
//
// Optional feature: define BUS_DATAPATH_R0_ZERO_EN to make R0 read as zero
// and discard every write to it.
module bus_datapath_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input logic              clk,
  input logic              clr,
  bus_datapath_seq_if.slave io
);
  localparam int RA_W = $clog2(NUM_REGS);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SHRA = 4'd6;
  localparam logic [3:0] OP_ROL  = 4'd7;
  localparam logic [3:0] OP_ROR  = 4'd8;
  localparam logic [3:0] OP_NEG  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_MFHI = 4'd13;
  localparam logic [3:0] OP_MFLO = 4'd14;
  localparam logic [3:0] OP_ILL  = 4'd15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T_Y    = 3'd1,
    T_ALU  = 3'd2,
    T_DIV  = 3'd3,
    T_WB   = 3'd4,
    T_WBHI = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] y, z_hi, z_lo, hi, lo;
  logic [SH_W-1:0]   cnt;
  logic [3:0]        op_q;
  logic [RA_W-1:0]   ra_q, rb_q, rc_q;
  logic              done_q, err_q;

  logic accept;
  logic is_long;   // MUL/DIV: results go to LO/HI, not the register file
  logic [DATA_W-1:0] bus_val;
  logic rf_we, ld_we, lo_we, hi_we, done_nxt, err_nxt;
  logic [DATA_W-1:0] rf_b, rf_c, rf_dbg;

  assign io.cmd_ready = (state == IDLE) && !io.ld_en;
  assign accept       = io.cmd_valid && io.cmd_ready;
  assign is_long      = (op_q == OP_MUL) || (op_q == OP_DIV);

  // Register-file read ports (bus sources and debug port).
  always_comb begin
    rf_b   = rf[rb_q];
    rf_c   = rf[rc_q];
    rf_dbg = rf[io.dbg_addr];
`ifdef BUS_DATAPATH_R0_ZERO_EN
    if (rb_q == '0)        rf_b   = '0;
    if (rc_q == '0)        rf_c   = '0;
    if (io.dbg_addr == '0) rf_dbg = '0;
`endif
  end

  // ALU: Y is the first operand, the bus (R[rc]) the second.
  logic [SH_W-1:0]     sh;
  logic [2*DATA_W-1:0] rol_w, ror_w, prod;
  logic [DATA_W-1:0]   alu_res;
  assign sh    = bus_val[SH_W-1:0];
  assign rol_w = {y, y} << sh;
  assign ror_w = {y, y} >> sh;
  // Sign-extending both operands to 2*DATA_W makes the low 2*DATA_W bits of
  // an unsigned multiply equal the signed product.
  assign prod  = {{DATA_W{y[DATA_W-1]}}, y} * {{DATA_W{bus_val[DATA_W-1]}}, bus_val};

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = y + bus_val;
      OP_SUB:  alu_res = y - bus_val;
      OP_AND:  alu_res = y & bus_val;
      OP_OR:   alu_res = y | bus_val;
      OP_SHL:  alu_res = y << sh;
      OP_SHR:  alu_res = y >> sh;
      OP_SHRA: alu_res = DATA_W'($signed(y) >>> sh);
      OP_ROL:  alu_res = rol_w[2*DATA_W-1:DATA_W];
      OP_ROR:  alu_res = ror_w[DATA_W-1:0];
      OP_NEG:  alu_res = '0 - bus_val;
      OP_NOT:  alu_res = ~bus_val;
      default: alu_res = '0;
    endcase
  end

  // Restoring divide step: Z_HI holds the partial remainder, Z_LO shifts the
  // dividend out and the quotient in, Y holds the divisor. A zero divisor
  // naturally yields an all-ones quotient and remainder equal to the dividend.
  logic [DATA_W:0] rem_sh, diff;
  assign rem_sh = {z_hi, z_lo[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, y};

  // FSM: state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (io.cmd_op == OP_ILL)                               state_nxt = IDLE;
          else if (io.cmd_op == OP_MFHI || io.cmd_op == OP_MFLO) state_nxt = T_WB;
          else                                                   state_nxt = T_Y;
        end
      end
      T_Y:     state_nxt = T_ALU;
      T_ALU:   state_nxt = (op_q == OP_DIV) ? T_DIV : T_WB;
      T_DIV:   state_nxt = (cnt == SH_W'(DATA_W - 1)) ? T_WB : T_DIV;
      T_WB:    state_nxt = is_long ? T_WBHI : IDLE;
      T_WBHI:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (bus source select and write strobes).
  always_comb begin
    bus_val  = '0;
    rf_we    = 1'b0;
    ld_we    = 1'b0;
    lo_we    = 1'b0;
    hi_we    = 1'b0;
    done_nxt = 1'b0;
    err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        ld_we    = io.ld_en;
        done_nxt = accept && (io.cmd_op == OP_ILL);
        err_nxt  = accept && (io.cmd_op == OP_ILL);
      end
      T_Y:   bus_val = rf_b;
      T_ALU: bus_val = rf_c;
      T_DIV: bus_val = z_lo;
      T_WB: begin
        if (op_q == OP_MFHI)      bus_val = hi;
        else if (op_q == OP_MFLO) bus_val = lo;
        else                      bus_val = z_lo;
        rf_we    = !is_long;
        lo_we    = is_long;
        done_nxt = !is_long;
      end
      T_WBHI: begin
        bus_val  = z_hi;
        hi_we    = 1'b1;
        done_nxt = 1'b1;
      end
      default: bus_val = '0;
    endcase
`ifdef BUS_DATAPATH_R0_ZERO_EN
    if (ra_q == '0)       rf_we = 1'b0;
    if (io.ld_addr == '0) ld_we = 1'b0;
`endif
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      y      <= '0;
      z_hi   <= '0;
      z_lo   <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_nxt;
      err_q  <= err_nxt;
      if (accept) begin
        op_q <= io.cmd_op;
        ra_q <= io.cmd_ra;
        rb_q <= io.cmd_rb;
        rc_q <= io.cmd_rc;
      end
      if (ld_we) rf[io.ld_addr] <= io.ld_data;
      if (rf_we) rf[ra_q] <= bus_val;
      if (lo_we) lo <= bus_val;
      if (hi_we) hi <= bus_val;
      case (state)
        T_Y: y <= bus_val;
        T_ALU: begin
          if (op_q == OP_MUL) begin
            {z_hi, z_lo} <= prod;
          end else if (op_q == OP_DIV) begin
            z_lo <= y;        // dividend
            z_hi <= '0;
            y    <= bus_val;  // divisor
            cnt  <= '0;
          end else begin
            z_lo <= alu_res;
          end
        end
        T_DIV: begin
          if (!diff[DATA_W]) begin
            z_hi <= diff[DATA_W-1:0];
            z_lo <= {z_lo[DATA_W-2:0], 1'b1};
          end else begin
            z_hi <= rem_sh[DATA_W-1:0];
            z_lo <= {z_lo[DATA_W-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io.dbg_data  = rf_dbg;
  assign io.bus_out   = bus_val;
  assign io.hi_out    = hi;
  assign io.lo_out    = lo;
  assign io.done      = done_q;
  assign io.err       = err_q;
  assign io.fsm_state = state;
endmodule

// File: tb/tb_bus_datapath_seq.sv
// tb_bus_datapath_seq
// Directed bench for bus_datapath_seq (DATA_W=32, NUM_REGS=16).
module tb_bus_datapath_seq;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  bus_datapath_seq_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) io ();

  bus_datapath_seq #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk (clk),
    .clr (clr),
    .io  (io)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic load(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    io.ld_en   = 1'b1;
    io.ld_addr = addr;
    io.ld_data = data;
    @(negedge clk);
    io.ld_en   = 1'b0;
  endtask

  task automatic reg_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    io.dbg_addr = addr;
    #1;
    check(tag, 64'(io.dbg_data), 64'(exp));
  endtask

  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] rc,
                         input int exp_lat, input logic exp_err);
    int lat;
    @(negedge clk);
    io.cmd_op    = op;
    io.cmd_ra    = ra;
    io.cmd_rb    = rb;
    io.cmd_rc    = rc;
    io.cmd_valid = 1'b1;
    check({tag, " ready"}, 64'(io.cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    io.cmd_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!io.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " err"}, 64'(io.err), 64'(exp_err));
    @(negedge clk);
    check({tag, " done once"}, 64'(io.done), 64'd0);
  endtask

  // Directed sequence
  initial begin
    int seen_done;
    total        = 0;
    bad          = 0;
    clr          = 1'b0;
    io.cmd_valid = 1'b0;
    io.cmd_op    = '0;
    io.cmd_ra    = '0;
    io.cmd_rb    = '0;
    io.cmd_rc    = '0;
    io.ld_en     = 1'b0;
    io.ld_addr   = '0;
    io.ld_data   = '0;
    io.dbg_addr  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst hi", 64'(io.hi_out), 64'd0);
    check("rst lo", 64'(io.lo_out), 64'd0);
    check("rst done", 64'(io.done), 64'd0);
    check("rst bus", 64'(io.bus_out), 64'd0);
    check("rst state", 64'(io.fsm_state), 64'd0);
    reg_check("rst r1", 4'd1, 32'h0);
    clr = 1'b1;
    @(negedge clk);
    check("idle ready", 64'(io.cmd_ready), 64'd1);

    // ADD
    load(4'd2, 32'h0000_0034);
    load(4'd3, 32'h0000_0045);
    run_cmd("add", 4'd0, 4'd1, 4'd2, 4'd3, 3, 1'b0);
    reg_check("add r1", 4'd1, 32'h0000_0079);
    // SUB with destination equal to source
    run_cmd("sub", 4'd1, 4'd3, 4'd3, 4'd2, 3, 1'b0);
    reg_check("sub r3", 4'd3, 32'h0000_0011);
    run_cmd("neg", 4'd9, 4'd11, 4'd0, 4'd2, 3, 1'b0);
    reg_check("neg r11", 4'd11, 32'hFFFF_FFCC);
    run_cmd("not", 4'd10, 4'd12, 4'd0, 4'd3, 3, 1'b0);
    reg_check("not r12", 4'd12, 32'hFFFF_FFEE);

    // Shifts / rotates
    load(4'd4, 32'h8000_0001);
    load(4'd5, 32'h0000_0004);
    run_cmd("ror", 4'd8, 4'd6, 4'd4, 4'd5, 3, 1'b0);
    reg_check("ror r6", 4'd6, 32'h1800_0000);
    run_cmd("shra", 4'd6, 4'd6, 4'd4, 4'd5, 3, 1'b0);
    reg_check("shra r6", 4'd6, 32'hF800_0000);
    run_cmd("rol", 4'd7, 4'd10, 4'd4, 4'd5, 3, 1'b0);
    reg_check("rol r10", 4'd10, 32'h0000_0018);
    run_cmd("shl", 4'd4, 4'd10, 4'd4, 4'd5, 3, 1'b0);
    reg_check("shl r10", 4'd10, 32'h0000_0010);
    run_cmd("shr", 4'd5, 4'd10, 4'd4, 4'd5, 3, 1'b0);
    reg_check("shr r10", 4'd10, 32'h0800_0000);
    run_cmd("or", 4'd3, 4'd13, 4'd4, 4'd5, 3, 1'b0);
    reg_check("or r13", 4'd13, 32'h8000_0005);

    // MUL and moves from HI/LO
    load(4'd2, 32'hFFFF_FFFE);
    load(4'd3, 32'h0000_0003);
    run_cmd("mul", 4'd11, 4'd0, 4'd2, 4'd3, 4, 1'b0);
    check("mul hi", 64'(io.hi_out), 64'hFFFF_FFFF);
    check("mul lo", 64'(io.lo_out), 64'hFFFF_FFFA);
    reg_check("mul r0 untouched", 4'd0, 32'h0);
    run_cmd("mflo", 4'd14, 4'd7, 4'd0, 4'd0, 1, 1'b0);
    reg_check("mflo r7", 4'd7, 32'hFFFF_FFFA);
    run_cmd("mfhi", 4'd13, 4'd8, 4'd0, 4'd0, 1, 1'b0);
    reg_check("mfhi r8", 4'd8, 32'hFFFF_FFFF);

    // DIV, including divide by zero
    load(4'd2, 32'd100);
    load(4'd3, 32'd7);
    run_cmd("div", 4'd12, 4'd0, 4'd2, 4'd3, 36, 1'b0);
    check("div lo", 64'(io.lo_out), 64'd14);
    check("div hi", 64'(io.hi_out), 64'd2);
    load(4'd3, 32'd0);
    run_cmd("div0", 4'd12, 4'd0, 4'd2, 4'd3, 36, 1'b0);
    check("div0 lo", 64'(io.lo_out), 64'hFFFF_FFFF);
    check("div0 hi", 64'(io.hi_out), 64'd100);

    // Illegal op
    run_cmd("ill", 4'd15, 4'd1, 4'd2, 4'd3, 0, 1'b1);
    reg_check("ill r1", 4'd1, 32'h0000_0079);
    check("ill hi", 64'(io.hi_out), 64'd100);
    check("ill state", 64'(io.fsm_state), 64'd0);

    // Load wins over an offered command
    @(negedge clk);
    io.cmd_op    = 4'd0;
    io.cmd_ra    = 4'd1;
    io.cmd_rb    = 4'd2;
    io.cmd_rc    = 4'd2;
    io.cmd_valid = 1'b1;
    io.ld_en     = 1'b1;
    io.ld_addr   = 4'd1;
    io.ld_data   = 32'h0000_ABCD;
    #1;
    check("ld prio ready", 64'(io.cmd_ready), 64'd0);
    @(negedge clk);
    io.cmd_valid = 1'b0;
    io.ld_en     = 1'b0;
    check("ld prio state", 64'(io.fsm_state), 64'd0);
    reg_check("ld prio r1", 4'd1, 32'h0000_ABCD);
    check("idle bus", 64'(io.bus_out), 64'd0);

    // Reset in the middle of a divide
    @(negedge clk);
    io.cmd_op    = 4'd12;
    io.cmd_ra    = 4'd0;
    io.cmd_rb    = 4'd2;
    io.cmd_rc    = 4'd3;
    io.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    io.cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid state", 64'(io.fsm_state), 64'd3);
    clr = 1'b0;
    #1;
    check("mid rst hi", 64'(io.hi_out), 64'd0);
    check("mid rst lo", 64'(io.lo_out), 64'd0);
    check("mid rst done", 64'(io.done), 64'd0);
    reg_check("mid rst r2", 4'd2, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("mid rel ready", 64'(io.cmd_ready), 64'd1);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (io.done) seen_done++;
    end
    check("mid no done", 64'(seen_done), 64'd0);

    // R0 behaviour
    load(4'd0, 32'd5);
`ifdef BUS_DATAPATH_R0_ZERO_EN
    reg_check("r0 load", 4'd0, 32'd0);
`else
    reg_check("r0 load", 4'd0, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
